conv1d_sched: RTL and testbench
===============================

CONV1D_SCHED -- requirements
Module: conv1d_sched

Interface
REQ-001 SHALL have parameter N, default 8, meaning input vector length.
REQ-002 SHALL have parameter K, default 3, meaning kernel length (1 <= K <= N).
REQ-003 SHALL have parameter MAC_LAT, default 4, meaning cycles from the last en_mult beat to the accumulator holding the final sum.
REQ-004 SHALL have ports: clk  in  1  clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: input_valid  in  1  load beat offered; input_ready  out  1  load beat accepted.
REQ-006 SHALL have ports: addr_w  out  $clog2(K)  kernel memory address; wr_en_w  out  1  kernel memory write.
REQ-007 SHALL have ports: addr_x  out  $clog2(N)  sample memory address; wr_en_x  out  1  sample memory write.
REQ-008 SHALL have ports: en_mult  out  1  MAC operand valid; clear_acc  out  1  accumulator clear.
REQ-009 SHALL have ports: output_valid  out  1  result ready; output_ready  in  1  consumer accepts.
REQ-010 SHALL have port busy  out  1  high in every state except LOAD_W.

Function
REQ-011 SHALL implement FSM states LOAD_W, LOAD_X, ISSUE, WAIT, OUT.
REQ-012 In LOAD_W: input_ready=1, wr_en_w=input_valid, addr_w=load count; after K accepted beats -> LOAD_X.
REQ-013 In LOAD_X: input_ready=1, wr_en_x=input_valid, addr_x=load count; after N accepted beats -> ISSUE with output index j=0 and tap index i=0.
REQ-014 Cycles with input_valid=0 in a load state SHALL not write and SHALL not advance the count.
REQ-015 In ISSUE: addr_x=j+i, addr_w=i, for K consecutive cycles (i=0..K-1), no stalls; then -> WAIT.
REQ-016 Memory read latency is 1 cycle; en_mult SHALL equal the ISSUE-state indicator delayed one cycle, so it is high for exactly K cycles per output.
REQ-017 WAIT SHALL last exactly MAC_LAT cycles counted from the cycle after the last en_mult beat; then -> OUT.
REQ-018 In OUT: output_valid=1 and held until output_ready=1; output_valid SHALL not drop without a handshake.
REQ-019 On the OUT handshake cycle, clear_acc SHALL pulse for exactly the next cycle; j increments.
REQ-020 If j was N-K (last output), the FSM SHALL go to LOAD_W; otherwise it SHALL return to ISSUE with i=0.
REQ-021 Total outputs per frame SHALL equal N-K+1; addr_x SHALL never exceed N-1.
REQ-022 wr_en_x and wr_en_w SHALL never be high together, and neither SHALL be high outside the load states.
REQ-023 input_ready SHALL be 0 in ISSUE, WAIT and OUT; input_valid there SHALL be ignored.
REQ-024 output_ready while output_valid=0 SHALL have no effect.
REQ-025 When K=N, exactly one output SHALL be produced, then -> LOAD_W.

Reset
REQ-026 Asserting reset at any time SHALL immediately force LOAD_W with all counters 0.
REQ-027 Reset values SHALL be: input_ready=1, output_valid=0, en_mult=0, clear_acc=1, wr_en_w=0, wr_en_x=0, addr_w=0, addr_x=0, busy=0.
REQ-028 clear_acc SHALL remain high until the first clock edge after reset deasserts.
REQ-029 A reset mid-frame SHALL discard partial loads and partial sums; no output_valid SHALL follow until a full reload.

Structure
REQ-030 State enum and default N/K/MAC_LAT constants SHALL live in shared package conv1d_pkg.
REQ-031 One sub-module, the existing Counter (parameterized width, synchronous clear, enable), SHALL be instantiated for the load, tap and output indices.
REQ-032 The memories and MAC are external; this block only sequences them.

Verification
REQ-033 Load w={1,2,3} and x={1..8} with continuous valid, output_ready=1 -> 6 results (14,20,26,32,38,44) from the MAC model, then input_ready=1.
REQ-034 Insert input_valid gaps of 2 cycles during both loads -> identical addresses written and identical results to REQ-033.
REQ-035 Hold output_ready=0 for 10 cycles on output 2 -> output_valid stays 1, addr/en_mult frozen, clear_acc one pulse after release.
REQ-036 Assert reset during WAIT of output 3 -> outputs at reset values next cycle; reload yields the REQ-033 results.
REQ-037 N=K=3, w={1,1,1}, x={2,3,4} -> one output of 9, then LOAD_W.
REQ-038 Assertions throughout: en_mult run length == K; wr_en_x & wr_en_w never both 1; addr_x < N.

Source files
------------

// File: rtl/conv1d_pkg.sv
// conv1d_pkg: shared constants for the conv1d_sched sequencer.
//   - default vector length, kernel length and MAC latency
//   - FSM state encodings
//   - width_of(): address/counter width helper that never returns 0
package conv1d_pkg;

  localparam int N_DEF       = 8;
  localparam int K_DEF       = 3;
  localparam int MAC_LAT_DEF = 4;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_LOAD_W = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD_X = 3'd1;
  localparam logic [ST_W-1:0] ST_ISSUE  = 3'd2;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd3;
  localparam logic [ST_W-1:0] ST_OUT    = 3'd4;

  // $clog2 of a count, floored at 1 bit so degenerate sizes still get a port.
  function automatic int width_of(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/conv1d_sched_counter.sv
// conv1d_sched_counter: up-counter with synchronous clear and enable.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear (wins over i_en)
//   i_en     : increment enable
//   o_cnt    : current count
module conv1d_sched_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/conv1d_sched.sv
// conv1d_sched: sequencer for an external 1-D convolution datapath
// (kernel memory, sample memory and MAC live outside this block).
//   clk, reset              : clock, asynchronous active-high reset
//   input_valid/input_ready : load beats, K kernel words then N samples
//   addr_w, wr_en_w         : kernel memory address / write strobe
//   addr_x, wr_en_x         : sample memory address / write strobe
//   en_mult                 : MAC operand valid (memory data arrives 1 cycle after address)
//   clear_acc               : accumulator clear, one cycle after each result handshake
//   output_valid/output_ready : result handshake, N-K+1 results per frame
//   busy                    : low only while waiting for kernel words
module conv1d_sched
  import conv1d_pkg::*;
#(
  parameter  int N       = N_DEF,
  parameter  int K       = K_DEF,
  parameter  int MAC_LAT = MAC_LAT_DEF,
  localparam int AWW     = width_of(K),
  localparam int AXW     = width_of(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           input_valid,
  output logic           input_ready,
  output logic [AWW-1:0] addr_w,
  output logic           wr_en_w,
  output logic [AXW-1:0] addr_x,
  output logic           wr_en_x,
  output logic           en_mult,
  output logic           clear_acc,
  output logic           output_valid,
  input  logic           output_ready,
  output logic           busy
);

  // Load, tap and output indices never exceed N-1, so all share the sample width.
  localparam int CW = AXW;
  localparam int WW = width_of(MAC_LAT + 1);

  localparam logic [CW-1:0] LAST_W    = CW'(K - 1);
  localparam logic [CW-1:0] LAST_X    = CW'(N - 1);
  localparam logic [CW-1:0] LAST_J    = CW'(N - K);
  localparam logic [WW-1:0] LAST_WAIT = WW'(MAC_LAT);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next_state;
  logic [WW-1:0]   r_wait;
  logic            r_en_mult;
  logic            r_clear;

  logic [CW-1:0] w_load_cnt;
  logic [CW-1:0] w_tap_cnt;
  logic [CW-1:0] w_out_cnt;

  logic w_load_fire;
  logic w_load_last;
  logic w_issue;
  logic w_issue_last;
  logic w_out_fire;
  logic w_out_last;
  logic w_wait_done;

  assign w_load_fire  = input_valid && ((r_state == ST_LOAD_W) || (r_state == ST_LOAD_X));
  assign w_load_last  = w_load_fire &&
                        (w_load_cnt == ((r_state == ST_LOAD_W) ? LAST_W : LAST_X));
  assign w_issue      = (r_state == ST_ISSUE);
  assign w_issue_last = w_issue && (w_tap_cnt == LAST_W);
  assign w_out_fire   = (r_state == ST_OUT) && output_ready;
  assign w_out_last   = w_out_fire && (w_out_cnt == LAST_J);
  // The first WAIT cycle carries the last en_mult beat; MAC_LAT more cycles follow.
  assign w_wait_done  = (r_state == ST_WAIT) && (r_wait == LAST_WAIT);

  conv1d_sched_counter #(.W(CW)) u_load_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (w_load_last),
    .i_en  (w_load_fire),
    .o_cnt (w_load_cnt)
  );

  conv1d_sched_counter #(.W(CW)) u_tap_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (w_issue_last),
    .i_en  (w_issue),
    .o_cnt (w_tap_cnt)
  );

  // Output index is cleared after the last result, so each frame starts at j=0.
  conv1d_sched_counter #(.W(CW)) u_out_cnt (
    .clk   (clk),
    .rst   (reset),
    .i_clr (w_out_last),
    .i_en  (w_out_fire),
    .o_cnt (w_out_cnt)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_LOAD_W: if (w_load_last)  w_next_state = ST_LOAD_X;
      ST_LOAD_X: if (w_load_last)  w_next_state = ST_ISSUE;
      ST_ISSUE:  if (w_issue_last) w_next_state = ST_WAIT;
      ST_WAIT:   if (w_wait_done)  w_next_state = ST_OUT;
      ST_OUT:    if (w_out_fire)   w_next_state = w_out_last ? ST_LOAD_W : ST_ISSUE;
      default:                     w_next_state = ST_LOAD_W;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_LOAD_W;
      r_wait    <= '0;
      r_en_mult <= 1'b0;
      // Held through reset so partial sums in the external MAC are discarded.
      r_clear   <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_en_mult <= w_issue;
      r_clear   <= w_out_fire;
      if ((r_state == ST_WAIT) && !w_wait_done) r_wait <= r_wait + WW'(1);
      else                                      r_wait <= '0;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    input_ready = 1'b0;
    wr_en_w     = 1'b0;
    wr_en_x     = 1'b0;
    addr_w      = '0;
    addr_x      = '0;
    case (r_state)
      ST_LOAD_W: begin
        input_ready = 1'b1;
        wr_en_w     = input_valid;
        addr_w      = w_load_cnt[AWW-1:0];
      end
      ST_LOAD_X: begin
        input_ready = 1'b1;
        wr_en_x     = input_valid;
        addr_x      = w_load_cnt;
      end
      ST_ISSUE: begin
        addr_w = w_tap_cnt[AWW-1:0];
        addr_x = w_out_cnt + w_tap_cnt;
      end
      default: ;
    endcase
  end

  assign en_mult      = r_en_mult;
  assign clear_acc    = r_clear;
  assign output_valid = (r_state == ST_OUT);
  assign busy         = (r_state != ST_LOAD_W);

endmodule

// File: tb/tb_conv1d_sched.sv
// tb_conv1d_sched: self-checking bench for conv1d_sched.
//   Unit 0: N=8, K=3, MAC_LAT=4.  Unit 1: N=K=3, MAC_LAT=4.
//   The bench models the external memories and MAC; expected results are
//   computed from the loaded vectors and queued when a frame is driven.
module tb_conv1d_sched;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   data = 0;

  logic [1:0] iv, ir, wrw, wrx, em, ca, ov, orr, bsy;
  logic [1:0] aw0, aw1, ax1;
  logic [2:0] ax0;
  logic [1:0] aw [2];
  logic [2:0] ax [2];

  assign aw[0] = aw0;
  assign aw[1] = aw1;
  assign ax[0] = ax0;
  assign ax[1] = {1'b0, ax1};

  always #5 clk = ~clk;

  conv1d_sched #(.N(8), .K(3), .MAC_LAT(4)) dut (
    .clk(clk), .reset(reset),
    .input_valid(iv[0]), .input_ready(ir[0]),
    .addr_w(aw0), .wr_en_w(wrw[0]),
    .addr_x(ax0), .wr_en_x(wrx[0]),
    .en_mult(em[0]), .clear_acc(ca[0]),
    .output_valid(ov[0]), .output_ready(orr[0]),
    .busy(bsy[0])
  );

  conv1d_sched #(.N(3), .K(3), .MAC_LAT(4)) dut_k (
    .clk(clk), .reset(reset),
    .input_valid(iv[1]), .input_ready(ir[1]),
    .addr_w(aw1), .wr_en_w(wrw[1]),
    .addr_x(ax1), .wr_en_x(wrx[1]),
    .en_mult(em[1]), .clear_acc(ca[1]),
    .output_valid(ov[1]), .output_ready(orr[1]),
    .busy(bsy[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Memory + MAC model: 1-cycle read latency, accumulate on en_mult, clear on clear_acc.
  int w_mem [2][4];
  int x_mem [2][8];
  int rd_w [2];
  int rd_x [2];
  int acc  [2];

  initial begin
    for (int t = 0; t < 2; t++) begin
      acc[t] = 0; rd_w[t] = 0; rd_x[t] = 0;
    end
  end

  always @(posedge clk) begin
    for (int t = 0; t < 2; t++) begin
      if (wrw[t]) w_mem[t][aw[t]] <= data;
      if (wrx[t]) x_mem[t][ax[t]] <= data;
      rd_w[t] <= w_mem[t][aw[t]];
      rd_x[t] <= x_mem[t][ax[t]];
      if (ca[t])      acc[t] <= 0;
      else if (em[t]) acc[t] <= acc[t] + rd_w[t] * rd_x[t];
    end
  end

  // Scoreboard and running invariants, sampled mid-cycle.
  int exp_q [$];
  int extra_out  = 0;
  int wr_viol    = 0;
  int range_viol = 0;
  int run [2]    = '{0, 0};

  always @(negedge clk) begin
    if (!reset) begin
      for (int t = 0; t < 2; t++) begin
        if (ov[t] && orr[t]) begin
          if (exp_q.size() == 0) extra_out++;
          else check("result", acc[t], exp_q.pop_front());
        end
        if (wrw[t] && wrx[t])            wr_viol++;
        if ((wrw[t] || wrx[t]) && !ir[t]) wr_viol++;
        if (int'(ax[t]) >= ((t == 0) ? 8 : 3)) range_viol++;
        if (em[t]) run[t]++;
        else if (run[t] != 0) begin
          check("en_mult_run", run[t], 3);
          run[t] = 0;
        end
      end
    end
  end

  task automatic push_conv(input int wv[$], input int xv[$], input int cnt);
    for (int j = 0; j < cnt; j++) begin
      int s;
      s = 0;
      for (int i = 0; i < wv.size(); i++) s += wv[i] * xv[j + i];
      exp_q.push_back(s);
    end
  endtask

  task automatic load_frame(input int u, input int wv[$], input int xv[$], input int gap);
    bit is_w;
    int idx;
    for (int b = 0; b < wv.size() + xv.size(); b++) begin
      is_w = (b < wv.size());
      idx  = is_w ? b : b - wv.size();
      @(posedge clk); #1;
      iv[u] = 1'b1;
      data  = is_w ? wv[idx] : xv[idx];
      @(negedge clk);
      check("load_flags", {ir[u], wrw[u], wrx[u]}, is_w ? 3'b110 : 3'b101);
      check("load_addr", is_w ? aw[u] : ax[u], idx);
      if (gap > 0) begin
        @(posedge clk); #1;
        iv[u] = 1'b0;
        data  = -1;
        repeat (gap) begin
          @(negedge clk);
          check("gap_idle", {wrw[u], wrx[u]}, 2'b00);
        end
      end
    end
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("drain_left", exp_q.size(), 0);
    @(negedge clk);
    check("idle_after_frame", {ir[u], bsy[u]}, 2'b10);
  endtask

  task automatic take_output(input int u, input int hold);
    int c;
    logic [4:0] snap;
    c = 0;
    @(negedge clk);
    while (!ov[u] && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("ov_seen", ov[u], 1);
    snap = {aw[u], ax[u]};
    if (hold > 0) iv[u] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_flags", {ov[u], em[u], ca[u], ir[u], wrw[u], wrx[u]}, 6'b100000);
      check("hold_addr", {aw[u], ax[u]}, snap);
    end
    iv[u] = 1'b0;
    @(posedge clk); #1;
    orr[u] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    orr[u] = 1'b0;
    @(negedge clk);
    check("clr_pulse", ca[u], 1);
    @(negedge clk);
    check("clr_end", ca[u], 0);
  endtask

  task automatic check_reset_state(input int u);
    check("rst_flags", {ir[u], ov[u], em[u], ca[u], wrw[u], wrx[u], bsy[u]}, 7'b1001000);
    check("rst_addr", {aw[u], ax[u]}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int w8[$];
  int x8[$];
  int w3[$];
  int x3[$];

  initial begin
    int c;
    int seen;
    w8 = '{1, 2, 3};
    x8 = '{1, 2, 3, 4, 5, 6, 7, 8};
    w3 = '{1, 1, 1};
    x3 = '{2, 3, 4};
    iv = '0;
    orr = '0;
    reset = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_state(0);
    check_reset_state(1);
    reset = 1'b0;
    #1;
    check("clr_hold_after_reset", ca, 2'b11);
    @(posedge clk); #1;
    check("clr_drop_after_edge", ca, 2'b00);

    // Continuous load, consumer always ready.
    orr[0] = 1'b1;
    push_conv(w8, x8, 6);
    load_frame(0, w8, x8, 0);
    drain(0);

    // Same frame with two-cycle gaps during both loads.
    push_conv(w8, x8, 6);
    load_frame(0, w8, x8, 2);
    drain(0);

    // Back-pressure: second result held for 10 cycles.
    orr[0] = 1'b0;
    push_conv(w8, x8, 6);
    load_frame(0, w8, x8, 0);
    for (int k = 0; k < 6; k++) take_output(0, (k == 1) ? 10 : 0);
    check("drain_after_hold", exp_q.size(), 0);
    @(negedge clk);
    check("idle_after_hold", {ir[0], bsy[0]}, 2'b10);

    // Reset during WAIT of the third result.
    orr[0] = 1'b1;
    push_conv(w8, x8, 2);
    load_frame(0, w8, x8, 0);
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin @(negedge clk); c++; end
    while (!em[0] && c < 2000) begin @(negedge clk); c++; end
    while (em[0] && c < 2000) begin @(negedge clk); c++; end
    check("reached_wait", {em[0], ov[0], bsy[0]}, 3'b001);
    reset = 1'b1;
    #1;
    check_reset_state(0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("no_output_after_reset", seen, 0);
    push_conv(w8, x8, 6);
    load_frame(0, w8, x8, 0);
    drain(0);

    // N = K = 3: exactly one output, then back to LOAD_W.
    orr[1] = 1'b1;
    push_conv(w3, x3, 1);
    load_frame(1, w3, x3, 0);
    drain(1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[1]) seen++;
    end
    check("single_output_k_eq_n", seen, 0);

    check("extra_outputs", extra_out, 0);
    check("write_strobe_violations", wr_viol, 0);
    check("addr_x_range_violations", range_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
